pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
Fetch-side sequencer that drives the 2-bit `choice` select and redirect target of the `pc` register.
- Decides each cycle among: boot to the reset vector, sequential advance, redirect to a branch/jump target, hold for stall, or halt.
- After every redirect it inserts a fixed number of flush bubbles.
- It keeps a count of redirects.
- Sits between decode/execute control and the `pc` block.

Parameters:
- FLUSH_CYCLES, 2, bubble cycles after a redirect (0..15; 0 means no FLUSH state).
- CNT_W, 16, width of `redirect_count`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  downstream stall; hold PC.
- branch_taken  in  1  branch resolved taken this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  unconditional jump this cycle.
- jump_target  in  32  jump destination.
- halt_req  in  1  level request to halt fetch.
- resume  in  1  single-cycle pulse that leaves HALT.
- choice  out  2  `pc` select: 00 = PC+4, 01 = load `pc_target`, 10 = hold, 11 = reset vector.
- pc_target  out  32  redirect address; valid only when choice = 01, otherwise 32'h0.
- fetch_valid  out  1  current fetch is on the correct path.
- flush  out  1  one-cycle pulse in the redirect cycle; kills younger instructions.
- halted  out  1  high while in HALT.
- misalign_err  out  1  one-cycle pulse when the selected target has bits [1:0] != 0.
- redirect_count  out  CNT_W  number of accepted redirects; wraps.

Behaviour:
- States: BOOT, RUN, FLUSH, HALT. Flush counter `fcnt` is 4 bits.
- Outputs `choice`, `pc_target`, `fetch_valid`, `flush` and `misalign_err` are combinational from state and inputs (Mealy). `halted` decodes state. `redirect_count` is registered.
- Reset low (asynchronous, any time, including mid-FLUSH or in HALT):
  - state = BOOT, fcnt = 0, redirect_count = 0.
  - Outputs: choice = 11, fetch_valid = 0, flush = 0, halted = 0, pc_target = 0, misalign_err = 0.
- BOOT:
  - choice = 11, fetch_valid = 0.
  - First rising edge with reset high moves to RUN. All other inputs are ignored.
- RUN: evaluate in this priority, highest first.
  1. halt_req: choice = 10, fetch_valid = 0; next state HALT.
  2. branch_taken or jump:
     - Selected target is branch_target if branch_taken, else jump_target. branch_taken beats jump when both are high.
     - If target[1:0] != 0: misalign_err = 1, choice = 10, fetch_valid = 0, no redirect, count unchanged; next state HALT.
     - Otherwise: choice = 01, pc_target = selected target, flush = 1, fetch_valid = 0, redirect_count += 1 (wraps at 2^CNT_W).
     - Next state is FLUSH with fcnt = FLUSH_CYCLES − 1, or RUN if FLUSH_CYCLES = 0.
     - A redirect overrides stall.
  3. stall: choice = 10, fetch_valid = 0.
  4. Otherwise: choice = 00, fetch_valid = 1.
- FLUSH:
  - fetch_valid = 0.
  - choice = 00, or 10 if stall is high; fcnt holds while stalled.
  - When not stalled: if fcnt == 0 go to RUN, else fcnt −= 1.
  - branch_taken, jump and halt_req are ignored (wrong-path). halt_req is level, so it takes effect on the first RUN cycle.
- HALT:
  - choice = 10, fetch_valid = 0, halted = 1.
  - resume moves to RUN on the next edge; choice is still 10 during the resume cycle.
  - resume is ignored outside HALT.
  - halt_req high in the cycle after resume re-enters HALT.
- Latency: a redirect asserted in cycle N loads `pc` at edge N+1. The first valid fetch from the target is in cycle N+1+FLUSH_CYCLES.

Test Plan:
1. Reset low for 2 cycles, then released → choice = 11 throughout reset and the first high cycle; then choice = 00, fetch_valid = 1; `pc` counts 0, 4, 8, …
2. RUN, branch_taken = 1, branch_target = 32'h100 for one cycle → choice = 01, pc_target = 32'h100, flush = 1, redirect_count = 1; next 2 cycles fetch_valid = 0, choice = 00; third cycle fetch_valid = 1.
3. branch_taken = 1 (target 32'h200), jump = 1 (target 32'h300) and stall = 1 in the same cycle → pc_target = 32'h200, choice = 01; stall is ignored.
4. jump_target = 32'h102 with jump = 1 → misalign_err pulses, choice = 10, halted = 1 next cycle, redirect_count unchanged; resume pulse → RUN, choice = 00 after the following edge.
5. Stall held 3 cycles during FLUSH → choice = 10 and fcnt frozen; FLUSH lasts 2 unstalled cycles in total.
6. Reset asserted mid-FLUSH with redirect_count = 5 → immediately choice = 11, redirect_count = 0, BOOT; with CNT_W = 2, 5 redirects → redirect_count = 1.

Source files
------------

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: control inputs and pc-select outputs of the fetch sequencer
interface pc_seq_ctrl_if #(parameter int CNT_W = 16);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             halt_req;
  logic             resume;
  logic [1:0]       choice;
  logic [31:0]      pc_target;
  logic             fetch_valid;
  logic             flush;
  logic             halted;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_count;
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
    input  choice, pc_target, fetch_valid, flush, halted, misalign_err, redirect_count
  );
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, halt_req, resume,
    output choice, pc_target, fetch_valid, flush, halted, misalign_err, redirect_count
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: picks the pc source each cycle (boot/advance/redirect/hold) and inserts flush bubbles
module pc_seq_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  pc_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
  localparam logic [3:0] FC_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);
  state_t           r_state, w_next;
  logic [3:0]       r_fcnt, w_fcnt_next;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       w_choice;
  logic [31:0]      w_target, w_sel;
  logic             w_fv, w_flush, w_mis, w_redir, w_req;
  assign w_req = bus.branch_taken | bus.jump;
  assign w_sel = bus.branch_taken ? bus.branch_target : bus.jump_target;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= BOOT;
      r_fcnt  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_fcnt  <= w_fcnt_next;
      r_count <= r_count + CNT_W'(w_redir);
    end
  always_comb begin
    w_next      = r_state;
    w_fcnt_next = r_fcnt;
    w_choice    = 2'b10;
    w_target    = '0;
    w_fv        = 1'b0;
    w_flush     = 1'b0;
    w_mis       = 1'b0;
    w_redir     = 1'b0;
    case (r_state)
      BOOT: begin
        w_choice = 2'b11;
        w_next   = RUN;
      end
      RUN:
        if (bus.halt_req) w_next = HALT;
        else if (w_req && w_sel[1:0] != 2'b00) begin
          w_mis  = 1'b1;
          w_next = HALT;
        end else if (w_req) begin
          w_choice    = 2'b01;
          w_target    = w_sel;
          w_flush     = 1'b1;
          w_redir     = 1'b1;
          w_next      = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
          w_fcnt_next = FC_INIT;
        end else if (!bus.stall) begin
          w_choice = 2'b00;
          w_fv     = 1'b1;
        end
      FLUSH:
        if (!bus.stall) begin
          w_choice    = 2'b00;
          w_next      = (r_fcnt == 4'd0) ? RUN : FLUSH;
          w_fcnt_next = (r_fcnt == 4'd0) ? r_fcnt : r_fcnt - 4'd1;
        end
      HALT:
        w_next = bus.resume ? RUN : HALT;
      default: w_next = BOOT;
    endcase
  end
  assign bus.choice         = w_choice;
  assign bus.pc_target      = w_target;
  assign bus.fetch_valid    = w_fv;
  assign bus.flush          = w_flush;
  assign bus.misalign_err   = w_mis;
  assign bus.halted         = (r_state == HALT);
  assign bus.redirect_count = r_count;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed per-cycle vectors queued as expectations, checked by an independent monitor
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pc_seq_ctrl_if #(.CNT_W(16)) bus ();
  pc_seq_ctrl_if #(.CNT_W(2))  bus2 ();
  pc_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  pc_seq_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  assign bus2.stall         = bus.stall;
  assign bus2.branch_taken  = bus.branch_taken;
  assign bus2.branch_target = bus.branch_target;
  assign bus2.jump          = bus.jump;
  assign bus2.jump_target   = bus.jump_target;
  assign bus2.halt_req      = bus.halt_req;
  assign bus2.resume        = bus.resume;
  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] tg;
    logic        fv, fl, hl, me;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  int   cyc_n = 0;
  int   checks = 0;
  int   failures = 0;
  task automatic cyc(input logic rst, st, bt, input logic [31:0] bta, input logic j,
                     input logic [31:0] jt, input logic h, r, input logic [1:0] ch,
                     input logic [31:0] tg, input logic fv, fl, hl, me, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.stall = st;
    bus.branch_taken = bt;
    bus.branch_target = bta;
    bus.jump = j;
    bus.jump_target = jt;
    bus.halt_req = h;
    bus.resume = r;
    q.push_back('{ch, tg, fv, fl, hl, me, cnt});
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = '{bus.choice, bus.pc_target, bus.fetch_valid, bus.flush, bus.halted,
            bus.misalign_err, bus.redirect_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle%0d outputs: got ch=%b tg=%h fv=%b fl=%b hl=%b me=%b cnt=%0d want ch=%b tg=%h fv=%b fl=%b hl=%b me=%b cnt=%0d",
                 cyc_n, a.ch, a.tg, a.fv, a.fl, a.hl, a.me, a.cnt, e.ch, e.tg, e.fv, e.fl, e.hl, e.me, e.cnt);
      end
      checks++;
      if (bus2.redirect_count !== e.cnt[1:0]) begin
        failures++;
        $display("FAIL cycle%0d count_w2: got %0d want %0d", cyc_n, bus2.redirect_count, e.cnt[1:0]);
      end
      cyc_n++;
    end
  end
  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.jump = 0;
    bus.jump_target = 0; bus.halt_req = 0; bus.resume = 0;
    //  rst st bt bta        j  jt         h  r  ch     tg         fv fl hl me cnt
    cyc(0, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b11, 32'h0,     0, 0, 0, 0, 0);
    cyc(0, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b11, 32'h0,     0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h40,    1, 32'h80,    1, 0, 2'b11, 32'h0,     0, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h100,   0, 32'h0,     0, 0, 2'b01, 32'h100,   0, 1, 0, 0, 0);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 1);
    cyc(1, 0, 0, 32'h0,     1, 32'h900,   0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 1);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 1);
    cyc(1, 1, 1, 32'h200,   1, 32'h300,   0, 0, 2'b01, 32'h200,   0, 1, 0, 0, 1);
    cyc(1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 2);
    cyc(1, 1, 0, 32'h0,     0, 32'h0,     0, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     1, 32'h102,   0, 0, 2'b10, 32'h0,     0, 0, 0, 1, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b10, 32'h0,     0, 0, 1, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 2'b10, 32'h0,     0, 0, 1, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     1, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     1, 1, 2'b10, 32'h0,     0, 0, 1, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     1, 0, 2'b10, 32'h0,     0, 0, 0, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 2'b10, 32'h0,     0, 0, 1, 0, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 2'b00, 32'h0,     1, 0, 0, 0, 2);
    cyc(1, 0, 1, 32'h201,   1, 32'h300,   0, 0, 2'b10, 32'h0,     0, 0, 0, 1, 2);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 1, 2'b10, 32'h0,     0, 0, 1, 0, 2);
    cyc(1, 0, 0, 32'h0,     1, 32'h500,   0, 0, 2'b01, 32'h500,   0, 1, 0, 0, 2);
    cyc(1, 0, 1, 32'h800,   0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 3);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 3);
    cyc(1, 0, 1, 32'h600,   0, 32'h0,     0, 0, 2'b01, 32'h600,   0, 1, 0, 0, 3);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     1, 0, 2'b00, 32'h0,     0, 0, 0, 0, 4);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 4);
    cyc(1, 0, 1, 32'h700,   0, 32'h0,     0, 0, 2'b01, 32'h700,   0, 1, 0, 0, 4);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     0, 0, 0, 0, 5);
    cyc(0, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b11, 32'h0,     0, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b11, 32'h0,     0, 0, 0, 0, 0);
    cyc(1, 0, 0, 32'h0,     0, 32'h0,     0, 0, 2'b00, 32'h0,     1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
